// File: rtl/boid_state_ram.sv
// Per-boid state store: x/y/vx/vy/ax/ay RAM arrays with spawn-pattern init sequencer.
// Define BOID_HIT_SCAN_EN to build the sequential pixel-occupancy scanner.
module boid_state_ram #(
    parameter int NUM_BOIDS = 16,
    parameter int X_W       = 28,
    parameter int Y_W       = 27,
    parameter int V_W       = 21,
    parameter int A_W       = 32,
    parameter int FRAC      = 16,
    parameter int X0        = 120,
    parameter int Y0        = 120,
    parameter int DXY       = 40,
    parameter int VX0       = 5,
    parameter int VY0       = 4,
    localparam int AW       = $clog2(NUM_BOIDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_req,
    output logic          init_busy,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [31:0]   x_out,
    output logic [31:0]   y_out,
    output logic [31:0]   vx_out,
    output logic [31:0]   vy_out,
    output logic [31:0]   ax_out,
    output logic [31:0]   ay_out,
    input  logic [5:0]    wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   x_in,
    input  logic [31:0]   y_in,
    input  logic [31:0]   vx_in,
    input  logic [31:0]   vy_in,
    input  logic [31:0]   ax_in,
    input  logic [31:0]   ay_in,
    input  logic          chk_start,
    input  logic [31:0]   chk_x,
    input  logic [31:0]   chk_y,
    output logic          chk_busy,
    output logic          chk_done,
    output logic          chk_hit
);
    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    localparam logic [AW-1:0] LAST    = AW'(NUM_BOIDS - 1);
    localparam logic [63:0]   INIT_VX = 64'(VX0) << FRAC;
    localparam logic [63:0]   INIT_VY = 64'(VY0) << FRAC;

    state_t          state;
    logic [AW-1:0]   init_cnt;
    logic [63:0]     init_x, init_y;
    logic            idle, init_wr, wr_ok, rd_acc;
    logic [5:0]      we;
    logic [AW-1:0]   w_idx, r_idx;
    logic            scan_issue;
    logic [AW-1:0]   scan_rd_idx;

    logic [X_W-1:0]  x_mem  [NUM_BOIDS];
    logic [Y_W-1:0]  y_mem  [NUM_BOIDS];
    logic [V_W-1:0]  vx_mem [NUM_BOIDS];
    logic [V_W-1:0]  vy_mem [NUM_BOIDS];
    logic [A_W-1:0]  ax_mem [NUM_BOIDS];
    logic [A_W-1:0]  ay_mem [NUM_BOIDS];
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [V_W-1:0]  vx_q, vy_q;
    logic [A_W-1:0]  ax_q, ay_q;

    logic            rd_oor;
    logic [5:0]      byp_mask;
    logic [5:0][31:0] byp_d;
    logic [5:0][31:0] fmt, hold;

    assign idle    = (state == ST_IDLE) && !init_req;
    assign init_wr = (state == ST_INIT) && init_busy;
    assign wr_ok   = idle && (32'(wr_addr) < 32'(NUM_BOIDS));
    assign we      = init_wr ? '1 : (wr_ok ? wr_en : '0);
    assign w_idx   = init_wr ? init_cnt : wr_addr;
    assign rd_acc  = idle && rd_req;
    assign r_idx   = scan_issue ? scan_rd_idx : rd_addr;

    always_comb begin
        init_x = (64'(X0) + 64'(DXY) * 64'(init_cnt)) << FRAC;
        init_y = (64'(Y0) + 64'(DXY) * 64'(init_cnt)) << FRAC;
    end

    // Single write port and single synchronous read port per field array.
    always_ff @(posedge clk) begin
        if (we[0]) x_mem[w_idx]  <= init_wr ? init_x[X_W-1:0]  : x_in[X_W-1:0];
        if (we[1]) y_mem[w_idx]  <= init_wr ? init_y[Y_W-1:0]  : y_in[Y_W-1:0];
        if (we[2]) vx_mem[w_idx] <= init_wr ? INIT_VX[V_W-1:0] : vx_in[V_W-1:0];
        if (we[3]) vy_mem[w_idx] <= init_wr ? INIT_VY[V_W-1:0] : vy_in[V_W-1:0];
        if (we[4]) ax_mem[w_idx] <= init_wr ? '0 : ax_in[A_W-1:0];
        if (we[5]) ay_mem[w_idx] <= init_wr ? '0 : ay_in[A_W-1:0];
        x_q  <= x_mem[r_idx];
        y_q  <= y_mem[r_idx];
        vx_q <= vx_mem[r_idx];
        vy_q <= vy_mem[r_idx];
        ax_q <= ax_mem[r_idx];
        ay_q <= ay_mem[r_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b0;
            rd_valid  <= 1'b0;
            rd_oor    <= 1'b0;
            byp_mask  <= '0;
            byp_d     <= '0;
            hold      <= '0;
        end else begin
            rd_valid <= rd_acc;
            hold     <= {ay_out, ax_out, vy_out, vx_out, y_out, x_out};
            if (rd_acc) begin
                rd_oor   <= !(32'(rd_addr) < 32'(NUM_BOIDS));
                byp_mask <= (wr_addr == rd_addr) ? we : '0;
                byp_d    <= {ay_in, ax_in, vy_in, vx_in, y_in, x_in};
            end
            case (state)
                ST_INIT: begin
                    // The first cycle after reset only arms init_busy; entry writes follow.
                    if (init_req) begin
                        init_cnt  <= '0;
                        init_busy <= 1'b1;
                    end else if (!init_busy) begin
                        init_busy <= 1'b1;
                    end else if (init_cnt == LAST) begin
                        state     <= ST_IDLE;
                        init_busy <= 1'b0;
                        init_cnt  <= '0;
                    end else begin
                        init_cnt <= init_cnt + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        state     <= ST_INIT;
                        init_cnt  <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        fmt    = '0;
        fmt[0] = 32'(signed'(byp_mask[0] ? byp_d[0][X_W-1:0] : x_q));
        fmt[1] = 32'(signed'(byp_mask[1] ? byp_d[1][Y_W-1:0] : y_q));
        fmt[2] = 32'(signed'(byp_mask[2] ? byp_d[2][V_W-1:0] : vx_q));
        fmt[3] = 32'(signed'(byp_mask[3] ? byp_d[3][V_W-1:0] : vy_q));
        fmt[4] = 32'(signed'(byp_mask[4] ? byp_d[4][A_W-1:0] : ax_q));
        fmt[5] = 32'(signed'(byp_mask[5] ? byp_d[5][A_W-1:0] : ay_q));
        if (rd_oor) fmt = '0;
    end

    assign x_out  = rd_valid ? fmt[0] : hold[0];
    assign y_out  = rd_valid ? fmt[1] : hold[1];
    assign vx_out = rd_valid ? fmt[2] : hold[2];
    assign vy_out = rd_valid ? fmt[3] : hold[3];
    assign ax_out = rd_valid ? fmt[4] : hold[4];
    assign ay_out = rd_valid ? fmt[5] : hold[5];

    logic unused_bits;
    assign unused_bits = ^{byp_d, init_x, init_y};

`ifdef BOID_HIT_SCAN_EN
    logic [AW-1:0]      scan_idx;
    logic               scan_all, scan_pend, scan_last, start_acc, hit_now;
    logic [31:0]        cx, cy;
    logic signed [31:0] sx, sy;

    assign start_acc   = idle && chk_start && !chk_busy;
    // User reads own the shared read port; the scan only advances on idle cycles.
    assign scan_issue  = idle && !rd_req && (start_acc || (chk_busy && !scan_all));
    assign scan_rd_idx = start_acc ? '0 : scan_idx;

    always_comb begin
        sx      = 32'(signed'(x_q));
        sy      = 32'(signed'(y_q));
        hit_now = ((sx >>> FRAC) == signed'(cx)) && ((sy >>> FRAC) == signed'(cy));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_busy  <= 1'b0;
            chk_done  <= 1'b0;
            chk_hit   <= 1'b0;
            scan_idx  <= '0;
            scan_all  <= 1'b0;
            scan_pend <= 1'b0;
            scan_last <= 1'b0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            chk_done  <= 1'b0;
            scan_pend <= scan_issue;
            if (init_req) begin
                chk_busy  <= 1'b0;
                scan_pend <= 1'b0;
            end else begin
                if (start_acc) begin
                    chk_busy <= 1'b1;
                    chk_hit  <= 1'b0;
                    cx       <= chk_x;
                    cy       <= chk_y;
                    scan_all <= 1'b0;
                    scan_idx <= '0;
                end
                if (scan_issue) begin
                    scan_idx  <= scan_rd_idx + AW'(1);
                    scan_last <= (scan_rd_idx == LAST);
                    scan_all  <= (scan_rd_idx == LAST);
                end
                if (scan_pend) begin
                    if (hit_now) chk_hit <= 1'b1;
                    if (scan_last) begin
                        chk_busy <= 1'b0;
                        chk_done <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign scan_issue  = 1'b0;
    assign scan_rd_idx = '0;
    assign chk_busy    = 1'b0;
    assign chk_done    = 1'b0;
    assign chk_hit     = 1'b0;

    logic unused_chk;
    assign unused_chk = ^{chk_start, chk_x, chk_y};
`endif

endmodule

// File: tb/tb_boid_state_ram.sv
// Directed bench for boid_state_ram (NUM_BOIDS=4); scan checks follow BOID_HIT_SCAN_EN.
module tb_boid_state_ram;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_req = 1'b0;
    logic        init_busy;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic        rd_valid;
    logic [31:0] x_out, y_out, vx_out, vy_out, ax_out, ay_out;
    logic [5:0]  wr_en = '0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] x_in = '0, y_in = '0, vx_in = '0, vy_in = '0, ax_in = '0, ay_in = '0;
    logic        chk_start = 1'b0;
    logic [31:0] chk_x = '0, chk_y = '0;
    logic        chk_busy, chk_done, chk_hit;

    int total = 0;
    int bad   = 0;
    int n;
    logic saw_done;

    boid_state_ram #(.NUM_BOIDS(4)) dut (
        .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .x_out(x_out), .y_out(y_out), .vx_out(vx_out), .vy_out(vy_out),
        .ax_out(ax_out), .ay_out(ay_out),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in), .ax_in(ax_in), .ay_in(ay_in),
        .chk_start(chk_start), .chk_x(chk_x), .chk_y(chk_y),
        .chk_busy(chk_busy), .chk_done(chk_done), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req  = 1'b0;
    endtask

    task automatic wait_init(output int cnt, output logic done_seen);
        cnt = 0;
        done_seen = 1'b0;
        while (init_busy && cnt < 20) begin
            if (chk_done) done_seen = 1'b1;
            cnt++;
            step();
        end
    endtask

    task automatic wait_done(inout int cnt);
        while (!chk_done && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        step();
        step();
        check("rst_busy", init_busy, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_x", x_out, 0);
        check("rst_chk", {chk_busy, chk_done, chk_hit}, 0);
        reset = 1'b1;
        step();
        check("busy_rise", init_busy, 1);
        wait_init(n, saw_done);
        check("init_len", n, 4);

        rd(2);
        check("rd2_valid", rd_valid, 1);
        check("rd2_x", x_out, 32'h00C8_0000);
        check("rd2_y", y_out, 32'h00C8_0000);
        check("rd2_vx", vx_out, 32'h0005_0000);
        check("rd2_vy", vy_out, 32'h0004_0000);
        check("rd2_ax", ax_out, 0);
        check("rd2_ay", ay_out, 0);
        step();
        check("rd2_novalid", rd_valid, 0);
        check("rd2_hold", x_out, 32'h00C8_0000);

        wr_en = 6'b000001; wr_addr = 2'd1; x_in = 32'hFFFF_0000;
        step();
        wr_en = '0;
        rd(1);
        check("wr1_x", x_out, 32'hFFFF_0000);
        check("wr1_y", y_out, 32'h00A0_0000);
        check("wr1_vx", vx_out, 32'h0005_0000);

        // y bit 26 and vx bit 20 are the stored MSBs: must sign-extend
        wr_en = 6'b000110; wr_addr = 2'd0; y_in = 32'h0400_0000; vx_in = 32'h0010_0000;
        step();
        wr_en = 6'b110000; ax_in = 32'h8000_0001; ay_in = 32'h1234_5678;
        step();
        wr_en = '0;
        rd(0);
        check("sx_y", y_out, 32'hFC00_0000);
        check("sx_vx", vx_out, 32'hFFF0_0000);
        check("sx_x", x_out, 32'h0078_0000);
        check("wr_ax", ax_out, 32'h8000_0001);
        check("wr_ay", ay_out, 32'h1234_5678);

        wr_en = 6'b000100; wr_addr = 2'd3; vx_in = 32'h0001_0000;
        rd_req = 1'b1; rd_addr = 2'd3;
        step();
        wr_en = '0; rd_req = 1'b0;
        check("byp_vx", vx_out, 32'h0001_0000);
        check("byp_x", x_out, 32'h00F0_0000);
        check("byp_vy", vy_out, 32'h0004_0000);

        rd_req = 1'b1; rd_addr = 2'd0;
        step();
        check("b2b_0", x_out, 32'h0078_0000);
        rd_addr = 2'd1;
        step();
        rd_req = 1'b0;
        check("b2b_1", x_out, 32'hFFFF_0000);
        check("b2b_valid", rd_valid, 1);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        rd_req = 1'b1; rd_addr = 2'd1;
        wr_en = 6'b000001; wr_addr = 2'd2; x_in = 32'h0;
        n = 0;
        while (init_busy && n < 20) begin
            check("rd_in_init", rd_valid, 0);
            n++;
            step();
        end
        rd_req = 1'b0; wr_en = '0;
        check("reinit_len", n, 4);
        check("reinit_valid", rd_valid, 0);
        rd(1);
        check("reinit_x1", x_out, 32'h00A0_0000);
        rd(2);
        check("init_wr_ignored", x_out, 32'h00C8_0000);
        rd(3);
        check("reinit_vx3", vx_out, 32'h0005_0000);

`ifdef BOID_HIT_SCAN_EN
        chk_x = 160; chk_y = 160; chk_start = 1'b1;
        step();
        n = 1;
        chk_x = 999; chk_y = 999;
        check("scan_busy", chk_busy, 1);
        step();
        n++;
        chk_start = 1'b0;
        wait_done(n);
        check("scan_hit_lat", n, 5);
        check("scan_hit", chk_hit, 1);
        check("scan_busy_fall", chk_busy, 0);
        step();
        check("done_pulse", chk_done, 0);
        check("hit_held", chk_hit, 1);

        chk_x = 161; chk_y = 160; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        n = 1;
        wait_done(n);
        check("miss_lat", n, 5);
        check("miss_hit", chk_hit, 0);

        chk_x = 240; chk_y = 240; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        n = 1;
        wait_done(n);
        check("last_hit", chk_hit, 1);

        chk_x = 160; chk_y = 160; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        step();
        n = 2;
        rd_req = 1'b1; rd_addr = 2'd0;
        repeat (3) begin
            step();
            n++;
        end
        rd_req = 1'b0;
        check("stall_rd_x", x_out, 32'h0078_0000);
        wait_done(n);
        check("stall_lat", n, 8);
        check("stall_hit", chk_hit, 1);

        chk_x = 200; chk_y = 200; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        step();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("abort_busy", chk_busy, 0);
        wait_init(n, saw_done);
        check("abort_nodone", saw_done, 0);
        check("abort_init_len", n, 4);

        rd(2);
        chk_x = 160; chk_y = 160; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        step();
        step();
        check("pre_rst_hit", chk_hit, 1);
`else
        chk_x = 160; chk_y = 160; chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        check("noscan_ties", {chk_busy, chk_done, chk_hit}, 0);
        rd(2);
        step();
`endif
        reset = 1'b0;
        #1;
        check("mid_rst_x", x_out, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_chk", {chk_busy, chk_done, chk_hit}, 0);
        step();
        reset = 1'b1;
        step();
        wait_init(n, saw_done);
        check("rst_init_len", n, 4);
        check("rst_nodone", saw_done, 0);
        rd(1);
        check("rst_x1", x_out, 32'h00A0_0000);

        init_req = 1'b1;
        step();
        init_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("init_rst_busy", init_busy, 0);
        step();
        reset = 1'b1;
        step();
        check("init_rst_rise", init_busy, 1);
        wait_init(n, saw_done);
        check("init_rst_len", n, 4);
        rd(3);
        check("final_x3", x_out, 32'h00F0_0000);
        check("final_y3", y_out, 32'h00F0_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/boid_state_ram.md
Name: boid_state_ram

Overview:
- Parametrised per-boid state store for the boid accelerator.
- Holds x, y, vx, vy, ax, ay for NUM_BOIDS boids in RAM-inferable arrays (one array per field, one write port and one read port each), so large boid counts fit in M10K.
- An internal sequencer loads the spawn pattern after reset or on request.
- Presents a registered 32-bit read port, a field-masked write port, and an optional sequential pixel-occupancy scanner.

Parameters:
- NUM_BOIDS, 16, number of boid entries; minimum 2.
- X_W, 28, stored width of x (signed fixed point).
- Y_W, 27, stored width of y.
- V_W, 21, stored width of vx and vy.
- A_W, 32, stored width of ax and ay.
- FRAC, 16, fractional bits in all fields.
- X0, 120, integer x of boid 0 at init.
- Y0, 120, integer y of boid 0 at init.
- DXY, 40, integer x/y step per boid index at init.
- VX0, 5, integer init vx.
- VY0, 4, integer init vy.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse: restart the init sequence.
- init_busy  out  1  high while the init sequence runs.
- rd_req  in  1  read request.
- rd_addr  in  $clog2(NUM_BOIDS)  read index.
- rd_valid  out  1  read data valid.
- x_out, y_out, vx_out, vy_out, ax_out, ay_out  out  32 each  read data, sign-extended.
- wr_en  in  6  field write mask; bit 0..5 = x, y, vx, vy, ax, ay.
- wr_addr  in  $clog2(NUM_BOIDS)  write index.
- x_in, y_in, vx_in, vy_in, ax_in, ay_in  in  32 each  write data.
- chk_start  in  1  start an occupancy scan.
- chk_x, chk_y  in  32 each  signed integer pixel to test.
- chk_busy  out  1  scan in progress.
- chk_done  out  1  one-cycle pulse at scan end.
- chk_hit  out  1  scan result; held until the next chk_start is accepted.

Behaviour:
- Reset state:
  - reset low drives all outputs to 0 and the FSM to INIT with the init counter at 0.
  - init_busy goes to 1 on the first clock after reset releases.
- FSM states:
  - INIT: writes entry i each cycle. Values are x=(X0+DXY*i)<<FRAC, y=(Y0+DXY*i)<<FRAC, vx=VX0<<FRAC, vy=VY0<<FRAC, ax=ay=0.
  - Init values are truncated to field width, modulo 2^W.
  - After entry NUM_BOIDS-1 the FSM moves to IDLE and init_busy falls. Init takes NUM_BOIDS cycles.
  - IDLE: serves reads, writes and scans.
  - init_req in IDLE returns the FSM to INIT at entry 0 and aborts any scan (no chk_done).
  - init_req during INIT restarts the counter at 0.
- During INIT:
  - rd_req, wr_en and chk_start are ignored.
  - rd_valid, chk_busy and chk_done stay 0.
- Write:
  - Each field whose wr_en bit is 1 stores the low W bits of its input at wr_addr on the clock edge.
  - wr_en=0 means no write.
- Read:
  - rd_req=1 in cycle N gives rd_valid=1 and the data in cycle N+1; latency is exactly 1.
  - Back-to-back reads give one result per cycle.
  - Output data holds its last value when rd_valid=0.
- Output formatting: each field is sign-extended from its stored MSB to 32 bits.
- Read and write to the same address in the same cycle: written fields return the new data (bypass); unwritten fields return the stored data.
- Out-of-range addresses (at or above NUM_BOIDS) are ignored for writes. Reads of such addresses return 0 with rd_valid=1.

Optional Feature:
- Macro: BOID_HIT_SCAN_EN.
- With the macro defined:
  - chk_start in IDLE while not busy latches chk_x/chk_y, sets chk_busy, clears chk_hit and starts a scan at entry 0.
  - Each cycle in which rd_req=0, the scanner reads one entry. rd_req has priority and stalls the scan.
  - A hit is when (x>>>FRAC) sign-extended equals chk_x and (y>>>FRAC) sign-extended equals chk_y.
  - The scan always covers all NUM_BOIDS entries. With no stalls it finishes in NUM_BOIDS+1 cycles, with chk_done pulsing and chk_busy falling together.
  - chk_hit is the OR of all hits.
  - chk_start while busy is ignored.
  - Writes during a scan are visible to entries not yet read.
- Without the macro: no scanner logic is built; chk_busy, chk_done and chk_hit are tied to 0 and chk inputs are unused.

Test Plan:
- NUM_BOIDS=4: release reset -> init_busy high for 4 cycles. Then read addr 2 -> x_out=0x00C80000, y_out=0x00C80000, vx_out=0x00050000, vy_out=0x00040000, ax_out=ay_out=0, rd_valid one cycle after rd_req.
- Write wr_en=6'b000001, addr 1, x_in=0xFFFF0000, then read 1 -> x_out=0xFFFF0000 sign-extended, all other fields unchanged (y_out=0x00A00000).
- Same-cycle write vx addr 3 = 0x00010000 with read addr 3 -> vx_out=0x00010000 next cycle; x_out=0x00F00000.
- Assert init_req after writes -> init_busy 4 cycles; then entry 1 reads x_out=0x00A00000 again; any rd_req during INIT gives rd_valid=0.
- BOID_HIT_SCAN_EN: chk_start with chk_x=160, chk_y=160 -> chk_done 5 cycles later, chk_hit=1. Repeat with chk_x=161 -> chk_hit=0. Hold rd_req for 3 cycles mid-scan -> chk_done delayed by exactly 3 cycles.
- Assert reset mid-scan and mid-INIT -> all outputs 0 immediately; init restarts from entry 0 after release with no chk_done pulse.
